// File: rtl/pio_bus_master.sv
// pio_bus_master
// Originates NMOS-6502-style bus cycles on the 8502 socket from a simple
// host request interface, generating its own phi2 clock.  Used for board
// bring-up, memory test and DMA-style transfers when no CPU is fitted.
//
// Parameters:
//   PHASE_TICKS  sysclk ticks per phi2 half-period (2..255)
//   IDLE_ADDR    address of the dummy read run when no request is pending
//
// Ports:
//   sysclk, _reset          system clock, async active-low reset
//   phi2                    generated bus clock (low = phi1, high = phi2)
//   address_8502, r_w_8502  bus address / direction, tri-state when not owned
//   data_8502               bidirectional data, driven in phi2 of a write
//   aec                     1 = master owns the bus
//   _rdy_8502               active-low read stall
//   req_*                   host request (valid/ready handshake)
//   rsp_*                   one-tick completion pulse with read data

module pio_bus_master #(
  parameter int          PHASE_TICKS = 4,
  parameter logic [15:0] IDLE_ADDR   = 16'hFFFF
) (
  input  logic        sysclk,
  input  logic        _reset,
  output logic        phi2,
  output logic [15:0] address_8502,
  output logic        r_w_8502,
  inout  wire  [7:0]  data_8502,
  input  logic        aec,
  input  logic        _rdy_8502,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic        rsp_rw,
  output logic [7:0]  rsp_rdata
);

  typedef enum logic [2:0] {
    CYC_OFF,
    CYC_IDLE,
    CYC_READ,
    CYC_WRITE,
    CYC_STALL
  } cyc_state_t;

  localparam logic [7:0] LAST_TICK = 8'(PHASE_TICKS - 1);

  logic [7:0]  phase_cnt;
  cyc_state_t  cyc_state;

  // One-entry holding register filled by the host handshake
  logic        hold_full;
  logic        hold_rw;
  logic [15:0] hold_addr;
  logic [7:0]  hold_wdata;

  // The cycle currently on the bus
  logic        cur_rw;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;

  // aborted: aec was lost during the current host cycle
  // retry:   an aborted host cycle is waiting to be re-run
  logic        aborted;
  logic        retry;

  logic        phi1_start;
  logic        active;
  logic        abort_now;
  logic        stall_now;
  logic        complete_now;
  logic        retry_pend;
  logic        accept;
  logic        consume;
  logic        hold_full_next;
  logic        bus_drive;

  // Decisions taken on the phi1-start tick.  That tick is also the last
  // tick of the previous phi2-high phase, so completion of the old cycle
  // and selection of the new one happen on the same edge.
  always_comb begin
    phi1_start     = phi2 && (phase_cnt == LAST_TICK);
    active         = (cyc_state == CYC_READ) || (cyc_state == CYC_WRITE) ||
                     (cyc_state == CYC_STALL);
    abort_now      = active && (aborted || !aec);
    stall_now      = ((cyc_state == CYC_READ) || (cyc_state == CYC_STALL)) &&
                     !_rdy_8502 && !abort_now;
    complete_now   = active && !abort_now && !stall_now;
    retry_pend     = retry || abort_now;
    accept         = req_valid && req_ready;
    // A pending retry or a stall keeps the holding register untouched.
    consume        = phi1_start && aec && !stall_now && !retry_pend && hold_full;
    hold_full_next = consume ? accept : (hold_full || accept);
    bus_drive      = aec && (cyc_state != CYC_OFF);
  end

  // Bus drivers release combinationally as soon as aec drops.
  assign address_8502 = bus_drive ? cur_addr : 16'hzzzz;
  assign r_w_8502     = bus_drive ? cur_rw   : 1'bz;
  assign data_8502    = (aec && phi2 && (cyc_state == CYC_WRITE)) ? cur_wdata : 8'hzz;

  // Phase counter, phi2 generation, holding register and the cycle FSM.
  always_ff @(posedge sysclk or negedge _reset) begin
    if (!_reset) begin
      phase_cnt  <= 8'd0;
      phi2       <= 1'b0;
      cyc_state  <= CYC_OFF;
      hold_full  <= 1'b0;
      hold_rw    <= 1'b1;
      hold_addr  <= 16'h0000;
      hold_wdata <= 8'h00;
      cur_rw     <= 1'b1;
      cur_addr   <= IDLE_ADDR;
      cur_wdata  <= 8'h00;
      aborted    <= 1'b0;
      retry      <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rw     <= 1'b0;
      rsp_rdata  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;

      if (phase_cnt == LAST_TICK) begin
        phase_cnt <= 8'd0;
        phi2      <= ~phi2;
      end else begin
        phase_cnt <= phase_cnt + 8'd1;
      end

      // On a simultaneous accept and issue, the issue below already uses
      // the old contents because of non-blocking assignment.
      if (accept) begin
        hold_rw    <= req_rw;
        hold_addr  <= req_addr;
        hold_wdata <= req_wdata;
      end
      hold_full <= hold_full_next;
      req_ready <= !hold_full_next;

      if (phi1_start) begin
        aborted <= 1'b0;

        if (complete_now) begin
          rsp_valid <= 1'b1;
          rsp_rw    <= cur_rw;
          rsp_rdata <= cur_rw ? data_8502 : 8'h00;
        end

        if (!aec) begin
          cyc_state <= CYC_OFF;
          retry     <= retry_pend;
        end else if (stall_now) begin
          cyc_state <= CYC_STALL;
        end else if (retry_pend) begin
          // Re-run the aborted cycle in full, ahead of the holding register.
          cyc_state <= cur_rw ? CYC_READ : CYC_WRITE;
          retry     <= 1'b0;
        end else if (hold_full) begin
          cyc_state <= hold_rw ? CYC_READ : CYC_WRITE;
          cur_rw    <= hold_rw;
          cur_addr  <= hold_addr;
          cur_wdata <= hold_wdata;
        end else begin
          cyc_state <= CYC_IDLE;
          cur_rw    <= 1'b1;
          cur_addr  <= IDLE_ADDR;
        end
      end else if (active && !aec) begin
        aborted <= 1'b1;
      end
    end
  end

endmodule
